// File: rtl/p_mul_arbiter.sv
// Two-requester front end for one shared packed multiplier: arbitrate, register operands, return result.
// Define P_MUL_ARB_RR_EN for round-robin; otherwise requester 0 has fixed priority.
module p_mul_arbiter (
    input  logic        clock,
    input  logic        reset,
    input  logic        r0_valid,
    output logic        r0_ready,
    input  logic        r0_mul_l,
    input  logic        r0_mul_h,
    input  logic        r0_clmul,
    input  logic [4:0]  r0_pw,
    input  logic [31:0] r0_crs1,
    input  logic [31:0] r0_crs2,
    output logic [31:0] r0_result,
    input  logic        r1_valid,
    output logic        r1_ready,
    input  logic        r1_mul_l,
    input  logic        r1_mul_h,
    input  logic        r1_clmul,
    input  logic [4:0]  r1_pw,
    input  logic [31:0] r1_crs1,
    input  logic [31:0] r1_crs2,
    output logic [31:0] r1_result,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_mul_l,
    output logic        m_mul_h,
    output logic        m_clmul,
    output logic [4:0]  m_pw,
    output logic [31:0] m_crs1,
    output logic [31:0] m_crs2,
    input  logic [31:0] m_result
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_grant;
    logic        w_sel1;
    logic        w_any;
    logic        r_mul_l;
    logic        r_mul_h;
    logic        r_clmul;
    logic [4:0]  r_pw;
    logic [31:0] r_crs1;
    logic [31:0] r_crs2;
    logic [31:0] r_result;
`ifdef P_MUL_ARB_RR_EN
    logic        r_last;
`endif

    // Requester 1 wins only when alone, or (round-robin) when requester 0 was served last.
    always_comb begin
        w_any = r0_valid | r1_valid;
`ifdef P_MUL_ARB_RR_EN
        w_sel1 = r1_valid & (~r0_valid | ~r_last);
`else
        w_sel1 = r1_valid & ~r0_valid;
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_any) w_state_nxt = ST_BUSY;
            ST_BUSY: if (m_ready) w_state_nxt = ST_RESP;
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_grant  <= 1'b0;
            r_mul_l  <= 1'b0;
            r_mul_h  <= 1'b0;
            r_clmul  <= 1'b0;
            r_pw     <= 5'd0;
            r_crs1   <= 32'd0;
            r_crs2   <= 32'd0;
            r_result <= 32'd0;
        end else begin
            if (r_state == ST_IDLE && w_any) begin
                r_grant <= w_sel1;
                r_mul_l <= w_sel1 ? r1_mul_l : r0_mul_l;
                r_mul_h <= w_sel1 ? r1_mul_h : r0_mul_h;
                r_clmul <= w_sel1 ? r1_clmul : r0_clmul;
                r_pw    <= w_sel1 ? r1_pw    : r0_pw;
                r_crs1  <= w_sel1 ? r1_crs1  : r0_crs1;
                r_crs2  <= w_sel1 ? r1_crs2  : r0_crs2;
            end
            if (r_state == ST_BUSY && m_ready) begin
                r_result <= m_result;
            end
        end
    end

`ifdef P_MUL_ARB_RR_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            r_last <= 1'b1;
        end else if (r_state == ST_RESP) begin
            r_last <= r_grant;
        end
    end
`endif

    assign m_valid   = (r_state == ST_BUSY);
    assign r0_ready  = (r_state == ST_RESP) & ~r_grant;
    assign r1_ready  = (r_state == ST_RESP) & r_grant;
    assign m_mul_l   = r_mul_l;
    assign m_mul_h   = r_mul_h;
    assign m_clmul   = r_clmul;
    assign m_pw      = r_pw;
    assign m_crs1    = r_crs1;
    assign m_crs2    = r_crs2;
    assign r0_result = r_result;
    assign r1_result = r_result;

endmodule

// File: tb/tb_p_mul_arbiter.sv
// Directed bench for p_mul_arbiter; expectations follow P_MUL_ARB_RR_EN when it is defined.
module tb_p_mul_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        r0_valid, r0_ready, r0_mul_l, r0_mul_h, r0_clmul;
    logic [4:0]  r0_pw;
    logic [31:0] r0_crs1, r0_crs2, r0_result;
    logic        r1_valid, r1_ready, r1_mul_l, r1_mul_h, r1_clmul;
    logic [4:0]  r1_pw;
    logic [31:0] r1_crs1, r1_crs2, r1_result;
    logic        m_valid, m_ready, m_mul_l, m_mul_h, m_clmul;
    logic [4:0]  m_pw;
    logic [31:0] m_crs1, m_crs2, m_result;

    int n_vec = 0;
    int n_err = 0;

    p_mul_arbiter dut (
        .clock(clock), .reset(reset),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_mul_l(r0_mul_l), .r0_mul_h(r0_mul_h),
        .r0_clmul(r0_clmul), .r0_pw(r0_pw), .r0_crs1(r0_crs1), .r0_crs2(r0_crs2),
        .r0_result(r0_result),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_mul_l(r1_mul_l), .r1_mul_h(r1_mul_h),
        .r1_clmul(r1_clmul), .r1_pw(r1_pw), .r1_crs1(r1_crs1), .r1_crs2(r1_crs2),
        .r1_result(r1_result),
        .m_valid(m_valid), .m_ready(m_ready), .m_mul_l(m_mul_l), .m_mul_h(m_mul_h),
        .m_clmul(m_clmul), .m_pw(m_pw), .m_crs1(m_crs1), .m_crs2(m_crs2),
        .m_result(m_result)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    logic exp_w1;
    int   r1_seen;

    initial begin
        reset = 1'b1;
        r0_valid = 0; r0_mul_l = 0; r0_mul_h = 0; r0_clmul = 0; r0_pw = 0; r0_crs1 = 0; r0_crs2 = 0;
        r1_valid = 0; r1_mul_l = 0; r1_mul_h = 0; r1_clmul = 0; r1_pw = 0; r1_crs1 = 0; r1_crs2 = 0;
        m_ready = 0; m_result = 0;
        tick(); tick();
        chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_r0_ready", {31'd0, r0_ready}, 32'd0);
        chk("rst_r1_ready", {31'd0, r1_ready}, 32'd0);
        chk("rst_m_crs1", m_crs1, 32'd0);
        chk("rst_result", r0_result, 32'd0);
        reset = 1'b0;

        // single request, multiplier answers in the first BUSY cycle
        r0_valid = 1; r0_pw = 5'b00001; r0_mul_l = 1; r0_crs1 = 32'h10; r0_crs2 = 32'h10;
        m_ready = 1; m_result = 32'h100;
        tick();
        chk("t1_m_valid", {31'd0, m_valid}, 32'd1);
        chk("t1_m_crs1", m_crs1, 32'h10);
        chk("t1_m_pw", {27'd0, m_pw}, 32'd1);
        chk("t1_m_mul_l", {31'd0, m_mul_l}, 32'd1);
        chk("t1_r0_ready_busy", {31'd0, r0_ready}, 32'd0);
        tick();
        chk("t1_r0_ready", {31'd0, r0_ready}, 32'd1);
        chk("t1_r1_ready", {31'd0, r1_ready}, 32'd0);
        chk("t1_m_valid_resp", {31'd0, m_valid}, 32'd0);
        chk("t1_result", r0_result, 32'h100);
        r0_valid = 0;
        tick();
        chk("t1_r0_ready_off", {31'd0, r0_ready}, 32'd0);
        chk("t1_m_valid_idle", {31'd0, m_valid}, 32'd0);

        // stall: m_ready low for 5 BUSY cycles, answer in the 6th
        r0_valid = 1; r0_pw = 5'b00100; r0_crs1 = 32'h21; r0_crs2 = 32'h22;
        m_ready = 0; m_result = 32'h4242;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("t2_m_valid", {31'd0, m_valid}, 32'd1);
            chk("t2_m_crs1", m_crs1, 32'h21);
            chk("t2_m_crs2", m_crs2, 32'h22);
            chk("t2_m_pw", {27'd0, m_pw}, 32'd4);
            chk("t2_r0_ready", {31'd0, r0_ready}, 32'd0);
            r0_crs1 = 32'hDEAD;
            tick();
        end
        chk("t2_still_busy", {31'd0, m_valid}, 32'd1);
        m_ready = 1;
        tick();
        chk("t2_r0_ready_t7", {31'd0, r0_ready}, 32'd1);
        chk("t2_result", r0_result, 32'h4242);
        r0_valid = 0;
        tick();

        // both requesters held continuously from reset
        reset = 1; tick(); reset = 0;
        r0_valid = 1; r0_crs1 = 32'h3; r1_valid = 1; r1_crs1 = 32'h5; m_result = 32'h77;
        r1_seen = 0;
        for (int op = 0; op < 7; op++) begin
`ifdef P_MUL_ARB_RR_EN
            exp_w1 = (op % 2) == 1;
`else
            exp_w1 = 1'b0;
`endif
            tick();
            chk("t3_m_crs1", m_crs1, exp_w1 ? 32'h5 : 32'h3);
            tick();
            chk("t3_r0_ready", {31'd0, r0_ready}, {31'd0, ~exp_w1});
            chk("t3_r1_ready", {31'd0, r1_ready}, {31'd0, exp_w1});
            if (r1_ready) r1_seen++;
            tick();
        end
`ifndef P_MUL_ARB_RR_EN
        chk("t3_r1_starved", r1_seen, 32'd0);
`endif
        r0_valid = 0; r1_valid = 0;
        tick();

        // operands changed after grant are ignored
        r1_valid = 1; r1_crs1 = 32'h1; r1_crs2 = 32'h7; m_ready = 0;
        tick();
        chk("t4_m_crs2_a", m_crs2, 32'h7);
        r1_crs2 = 32'h9;
        tick();
        chk("t4_m_crs2_b", m_crs2, 32'h7);
        m_ready = 1;
        tick();
        chk("t4_r1_ready", {31'd0, r1_ready}, 32'd1);
        chk("t4_m_crs2_c", m_crs2, 32'h7);
        r1_valid = 0;
        tick();

        // reset while BUSY
        r1_valid = 1; r1_crs1 = 32'h5; m_ready = 0;
        tick();
        chk("t5_busy", {31'd0, m_valid}, 32'd1);
        reset = 1; r1_valid = 0;
        tick();
        chk("t5_m_valid", {31'd0, m_valid}, 32'd0);
        chk("t5_m_crs1", m_crs1, 32'd0);
        reset = 0;
        for (int i = 0; i < 3; i++) begin
            chk("t5_no_ready", {30'd0, r0_ready, r1_ready}, 32'd0);
            tick();
        end
        r0_valid = 1; r0_crs1 = 32'h3; r1_valid = 1; m_ready = 1;
        tick();
        chk("t5_grant_r0", m_crs1, 32'h3);
        tick();
        chk("t5_r0_ready", {31'd0, r0_ready}, 32'd1);
        chk("t5_r1_ready", {31'd0, r1_ready}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
